// File: rtl/alu_rs.sv
// ALU reservation station: holds issued ALU/branch/jump ops until both operands are ready,
// snoops ALU/LSB result broadcasts, and dispatches the lowest-index ready entry each cycle.
module alu_rs #(
    parameter int unsigned RS_SIZE  = 16,
    parameter int unsigned ROB_BITS = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                rdy_i,
    input  logic                rollback_i,
    input  logic                issue_en_i,
    input  logic [6:0]          issue_opcode_i,
    input  logic [2:0]          issue_funct3_i,
    input  logic                issue_funct7_i,
    input  logic [31:0]         issue_val1_i,
    input  logic [31:0]         issue_val2_i,
    input  logic                issue_rdy1_i,
    input  logic                issue_rdy2_i,
    input  logic [ROB_BITS-1:0] issue_q1_i,
    input  logic [ROB_BITS-1:0] issue_q2_i,
    input  logic [31:0]         issue_imm_i,
    input  logic [ROB_BITS-1:0] issue_rob_pos_i,
    input  logic [31:0]         issue_pc_i,
    input  logic                alu_res_done_i,
    input  logic [ROB_BITS-1:0] alu_res_rob_pos_i,
    input  logic [31:0]         alu_res_cal_i,
    input  logic                lsb_res_done_i,
    input  logic [ROB_BITS-1:0] lsb_res_rob_pos_i,
    input  logic [31:0]         lsb_res_val_i,
    output logic                rs_full_o,
    output logic                alu_en_o,
    output logic [6:0]          alu_opcode_o,
    output logic [2:0]          alu_funct3_o,
    output logic                alu_funct7_o,
    output logic [31:0]         alu_val1_o,
    output logic [31:0]         alu_val2_o,
    output logic [31:0]         alu_imm_o,
    output logic [ROB_BITS-1:0] alu_rob_pos_o,
    output logic [31:0]         alu_pc_o
);

    localparam int unsigned IdxW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    typedef struct packed {
        logic [6:0]          opcode;
        logic [2:0]          funct3;
        logic                funct7;
        logic [31:0]         val1;
        logic [31:0]         val2;
        logic [31:0]         imm;
        logic [ROB_BITS-1:0] rob_pos;
        logic [31:0]         pc;
    } disp_t;

    typedef struct packed {
        logic                busy;
        logic                rdy1;
        logic                rdy2;
        logic [ROB_BITS-1:0] q1;
        logic [ROB_BITS-1:0] q2;
        disp_t               op;
    } entry_t;

    entry_t ent_q [RS_SIZE];
    entry_t ent_d [RS_SIZE];
    disp_t  disp_q, disp_d;
    logic   alu_en_q, alu_en_d;

    logic            free_found, sel_found;
    logic [IdxW-1:0] free_idx, sel_idx;

    // Returns {ready, value}; ALU broadcast wins if both buses carry the tag.
    function automatic logic [32:0] snoop(input logic rdy, input logic [ROB_BITS-1:0] q,
                                          input logic [31:0] val);
        if (rdy) return {1'b1, val};
        if (alu_res_done_i && (alu_res_rob_pos_i == q)) return {1'b1, alu_res_cal_i};
        if (lsb_res_done_i && (lsb_res_rob_pos_i == q)) return {1'b1, lsb_res_val_i};
        return {1'b0, val};
    endfunction

    // Downward scan so the lowest matching index is the one left standing.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        sel_found  = 1'b0;
        sel_idx    = '0;
        for (int i = int'(RS_SIZE) - 1; i >= 0; i--) begin
            if (!ent_q[i].busy) begin
                free_found = 1'b1;
                free_idx   = IdxW'(i);
            end
            if (ent_q[i].busy && ent_q[i].rdy1 && ent_q[i].rdy2) begin
                sel_found = 1'b1;
                sel_idx   = IdxW'(i);
            end
        end
    end

    assign rs_full_o = ~free_found;

    always_comb begin
        for (int i = 0; i < int'(RS_SIZE); i++) begin
            ent_d[i] = ent_q[i];
            if (ent_q[i].busy) begin
                {ent_d[i].rdy1, ent_d[i].op.val1} = snoop(ent_q[i].rdy1, ent_q[i].q1,
                                                          ent_q[i].op.val1);
                {ent_d[i].rdy2, ent_d[i].op.val2} = snoop(ent_q[i].rdy2, ent_q[i].q2,
                                                          ent_q[i].op.val2);
            end
        end

        alu_en_d = sel_found;
        disp_d   = disp_q;
        if (sel_found) begin
            disp_d               = ent_q[sel_idx].op;
            ent_d[sel_idx].busy = 1'b0;
        end

        if (issue_en_i && free_found) begin
            ent_d[free_idx].busy       = 1'b1;
            ent_d[free_idx].q1         = issue_q1_i;
            ent_d[free_idx].q2         = issue_q2_i;
            ent_d[free_idx].op.opcode  = issue_opcode_i;
            ent_d[free_idx].op.funct3  = issue_funct3_i;
            ent_d[free_idx].op.funct7  = issue_funct7_i;
            ent_d[free_idx].op.imm     = issue_imm_i;
            ent_d[free_idx].op.rob_pos = issue_rob_pos_i;
            ent_d[free_idx].op.pc      = issue_pc_i;
            {ent_d[free_idx].rdy1, ent_d[free_idx].op.val1} =
                snoop(issue_rdy1_i, issue_q1_i, issue_val1_i);
            {ent_d[free_idx].rdy2, ent_d[free_idx].op.val2} =
                snoop(issue_rdy2_i, issue_q2_i, issue_val2_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(RS_SIZE); i++) ent_q[i] <= '0;
            alu_en_q <= 1'b0;
            disp_q   <= '0;
        end else if (rollback_i) begin
            for (int i = 0; i < int'(RS_SIZE); i++) ent_q[i].busy <= 1'b0;
            alu_en_q <= 1'b0;
        end else if (rdy_i) begin
            for (int i = 0; i < int'(RS_SIZE); i++) ent_q[i] <= ent_d[i];
            alu_en_q <= alu_en_d;
            disp_q   <= disp_d;
        end
    end

    assign alu_en_o      = alu_en_q;
    assign alu_opcode_o  = disp_q.opcode;
    assign alu_funct3_o  = disp_q.funct3;
    assign alu_funct7_o  = disp_q.funct7;
    assign alu_val1_o    = disp_q.val1;
    assign alu_val2_o    = disp_q.val2;
    assign alu_imm_o     = disp_q.imm;
    assign alu_rob_pos_o = disp_q.rob_pos;
    assign alu_pc_o      = disp_q.pc;

endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: vector table plus hand sequences, dispatches checked against a queue.
module tb_alu_rs;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        funct7;
        logic [31:0] val1;
        logic [31:0] val2;
        logic [31:0] imm;
        logic [3:0]  rob_pos;
        logic [31:0] pc;
    } bundle_t;

    typedef struct {
        bundle_t stim;
        bundle_t exp;
    } vec_t;

    logic        clk, rst_n, rdy, rollback, issue_en;
    logic [6:0]  issue_opcode;
    logic [2:0]  issue_funct3;
    logic        issue_funct7;
    logic [31:0] issue_val1, issue_val2, issue_imm, issue_pc;
    logic        issue_rdy1, issue_rdy2;
    logic [3:0]  issue_q1, issue_q2, issue_rob_pos;
    logic        alu_res_done, lsb_res_done;
    logic [3:0]  alu_res_rob_pos, lsb_res_rob_pos;
    logic [31:0] alu_res_cal, lsb_res_val;
    logic        rs_full, alu_en;
    logic [6:0]  alu_opcode;
    logic [2:0]  alu_funct3;
    logic        alu_funct7;
    logic [31:0] alu_val1, alu_val2, alu_imm, alu_pc;
    logic [3:0]  alu_rob_pos;

    alu_rs #(.RS_SIZE(16), .ROB_BITS(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .rdy_i(rdy), .rollback_i(rollback),
        .issue_en_i(issue_en), .issue_opcode_i(issue_opcode), .issue_funct3_i(issue_funct3),
        .issue_funct7_i(issue_funct7), .issue_val1_i(issue_val1), .issue_val2_i(issue_val2),
        .issue_rdy1_i(issue_rdy1), .issue_rdy2_i(issue_rdy2), .issue_q1_i(issue_q1),
        .issue_q2_i(issue_q2), .issue_imm_i(issue_imm), .issue_rob_pos_i(issue_rob_pos),
        .issue_pc_i(issue_pc), .alu_res_done_i(alu_res_done),
        .alu_res_rob_pos_i(alu_res_rob_pos), .alu_res_cal_i(alu_res_cal),
        .lsb_res_done_i(lsb_res_done), .lsb_res_rob_pos_i(lsb_res_rob_pos),
        .lsb_res_val_i(lsb_res_val), .rs_full_o(rs_full), .alu_en_o(alu_en),
        .alu_opcode_o(alu_opcode), .alu_funct3_o(alu_funct3), .alu_funct7_o(alu_funct7),
        .alu_val1_o(alu_val1), .alu_val2_o(alu_val2), .alu_imm_o(alu_imm),
        .alu_rob_pos_o(alu_rob_pos), .alu_pc_o(alu_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int      n_checks = 0;
    int      n_fail   = 0;
    bundle_t exp_q[$];
    bundle_t mon_e;
    logic    last_rdy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // A dispatch is an alu_en produced by an edge with rdy high; held alu_en is not re-counted.
    always @(posedge clk) last_rdy = rdy;

    always @(negedge clk) begin
        if (rst_n && alu_en && last_rdy) begin
            if (exp_q.size() == 0) begin
                check("unexpected_dispatch_rob", 32'(alu_rob_pos), 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("disp_opcode", 32'(alu_opcode), 32'(mon_e.opcode));
                check("disp_funct3", 32'(alu_funct3), 32'(mon_e.funct3));
                check("disp_funct7", 32'(alu_funct7), 32'(mon_e.funct7));
                check("disp_val1", alu_val1, mon_e.val1);
                check("disp_val2", alu_val2, mon_e.val2);
                check("disp_imm", alu_imm, mon_e.imm);
                check("disp_rob_pos", 32'(alu_rob_pos), 32'(mon_e.rob_pos));
                check("disp_pc", alu_pc, mon_e.pc);
            end
        end
    end

    function automatic bundle_t mk(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                   input logic [31:0] v1, input logic [31:0] v2,
                                   input logic [31:0] imm, input logic [3:0] rob,
                                   input logic [31:0] pc);
        bundle_t b;
        b.opcode = op; b.funct3 = f3; b.funct7 = f7; b.val1 = v1; b.val2 = v2;
        b.imm = imm; b.rob_pos = rob; b.pc = pc;
        return b;
    endfunction

    task automatic drive_issue(input bundle_t b, input logic r1, input logic [3:0] q1,
                               input logic r2, input logic [3:0] q2);
        issue_en = 1'b1;
        issue_opcode = b.opcode; issue_funct3 = b.funct3; issue_funct7 = b.funct7;
        issue_val1 = b.val1; issue_val2 = b.val2; issue_imm = b.imm;
        issue_rob_pos = b.rob_pos; issue_pc = b.pc;
        issue_rdy1 = r1; issue_q1 = q1; issue_rdy2 = r2; issue_q2 = q2;
    endtask

    task automatic drive_alu(input logic [3:0] tag, input logic [31:0] val);
        alu_res_done = 1'b1; alu_res_rob_pos = tag; alu_res_cal = val;
    endtask

    task automatic drive_lsb(input logic [3:0] tag, input logic [31:0] val);
        lsb_res_done = 1'b1; lsb_res_rob_pos = tag; lsb_res_val = val;
    endtask

    // One rising edge, then drop all single-cycle strobes.
    task automatic step();
        @(posedge clk);
        #1;
        issue_en = 1'b0; alu_res_done = 1'b0; lsb_res_done = 1'b0; rollback = 1'b0;
    endtask

    vec_t    tbl[6];
    bundle_t b, fill_b[16];

    initial begin
        rst_n = 1'b0; rdy = 1'b1; rollback = 1'b0; issue_en = 1'b0;
        issue_opcode = '0; issue_funct3 = '0; issue_funct7 = 1'b0;
        issue_val1 = '0; issue_val2 = '0; issue_imm = '0; issue_pc = '0;
        issue_rdy1 = 1'b0; issue_rdy2 = 1'b0; issue_q1 = '0; issue_q2 = '0; issue_rob_pos = '0;
        alu_res_done = 1'b0; alu_res_rob_pos = '0; alu_res_cal = '0;
        lsb_res_done = 1'b0; lsb_res_rob_pos = '0; lsb_res_val = '0;

        tbl[0].stim = mk(7'b0110111, 3'd0, 1'b0, 32'h0, 32'h0, 32'h1234_5000, 4'd1, 32'h100);
        tbl[1].stim = mk(7'b0010111, 3'd0, 1'b0, 32'h0, 32'h0, 32'hFFFF_F000, 4'd2, 32'h104);
        tbl[2].stim = mk(7'b1101111, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0000_0020, 4'd3, 32'h108);
        tbl[3].stim = mk(7'b1100011, 3'd5, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFF0,
                         4'd4, 32'h10C);
        tbl[4].stim = mk(7'b0010011, 3'd7, 1'b0, 32'hA5A5_A5A5, 32'h0, 32'h0000_00FF, 4'd5,
                         32'h110);
        tbl[5].stim = mk(7'b0110011, 3'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 4'd15,
                         32'hFFFF_FFFC);
        // The RS forwards the issued fields unchanged.
        for (int i = 0; i < 6; i++) tbl[i].exp = tbl[i].stim;

        #12;
        check("reset_alu_en", 32'(alu_en), 32'd0);
        check("reset_rs_full", 32'(rs_full), 32'd0);
        check("reset_val1", alu_val1, 32'd0);
        check("reset_pc", alu_pc, 32'd0);
        check("reset_opcode", 32'(alu_opcode), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Single ADD: one-cycle latency, one-cycle pulse.
        b = mk(7'b0110011, 3'd0, 1'b0, 32'd5, 32'd7, 32'd0, 4'd3, 32'h40);
        drive_issue(b, 1'b1, 4'd0, 1'b1, 4'd0);
        exp_q.push_back(b);
        step();
        @(negedge clk); check("add_not_same_edge", 32'(alu_en), 32'd0);
        step();
        @(negedge clk); check("add_dispatch", 32'(alu_en), 32'd1);
        step();
        @(negedge clk); check("add_pulse_end", 32'(alu_en), 32'd0);

        // Back-to-back table vectors.
        for (int i = 0; i < 6; i++) begin
            drive_issue(tbl[i].stim, 1'b1, 4'd0, 1'b1, 4'd0);
            exp_q.push_back(tbl[i].exp);
            step();
        end
        step(); step();
        check("table_drained", 32'(exp_q.size()), 32'd0);

        // rdy low freezes state and holds alu_en.
        b = mk(7'b0110011, 3'd4, 1'b0, 32'h0BAD_F00D, 32'h11, 32'h0, 4'd8, 32'h200);
        drive_issue(b, 1'b1, 4'd0, 1'b1, 4'd0);
        exp_q.push_back(b);
        step();
        rdy = 1'b0;
        step(); step();
        @(negedge clk); check("rdy_low_no_dispatch", 32'(alu_en), 32'd0);
        rdy = 1'b1;
        step();
        @(negedge clk); check("rdy_resume_dispatch", 32'(alu_en), 32'd1);
        rdy = 1'b0;
        step(); step();
        @(negedge clk);
        check("rdy_low_holds_en", 32'(alu_en), 32'd1);
        check("rdy_low_holds_val1", alu_val1, 32'h0BAD_F00D);
        rdy = 1'b1;
        step();
        @(negedge clk); check("rdy_resume_clears_en", 32'(alu_en), 32'd0);

        // Operand 1 woken by ALU broadcast three cycles after issue.
        b = mk(7'b0110011, 3'd0, 1'b0, 32'h0, 32'h22, 32'h0, 4'd7, 32'h300);
        drive_issue(b, 1'b0, 4'd2, 1'b1, 4'd0);
        step();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); check("wait_q1_idle", 32'(alu_en), 32'd0);
            step();
        end
        b.val1 = 32'h10;
        exp_q.push_back(b);
        drive_alu(4'd2, 32'h10);
        step();
        @(negedge clk); check("wake_not_same_edge", 32'(alu_en), 32'd0);
        step();
        @(negedge clk); check("wake_dispatch", 32'(alu_en), 32'd1);

        // Operand 2 bypassed from an LSB broadcast in the issue cycle.
        b = mk(7'b0110011, 3'd1, 1'b0, 32'h3, 32'hDEAD, 32'h0, 4'd9, 32'h400);
        drive_issue(b, 1'b1, 4'd0, 1'b0, 4'd6);
        drive_lsb(4'd6, 32'hABCD);
        b.val2 = 32'hABCD;
        exp_q.push_back(b);
        step();
        @(negedge clk); check("bypass_not_same_edge", 32'(alu_en), 32'd0);
        step();
        @(negedge clk); check("bypass_dispatch", 32'(alu_en), 32'd1);
        step();

        // Fill all 16 entries waiting on tag 9, then release them together.
        for (int i = 0; i < 16; i++) begin
            fill_b[i] = mk(7'b0110011, 3'(i % 8), 1'(i % 2), 32'h0, 32'h100 + 32'(i), 32'(i),
                           4'(i), 32'h1000 + 32'(4 * i));
            drive_issue(fill_b[i], 1'b0, 4'd9, 1'b1, 4'd0);
            step();
        end
        @(negedge clk);
        check("full_set", 32'(rs_full), 32'd1);
        check("full_idle", 32'(alu_en), 32'd0);
        drive_issue(mk(7'b0110011, 3'd0, 1'b0, 32'h1, 32'h1, 32'h0, 4'hE, 32'hBAD0), 1'b1,
                    4'd0, 1'b1, 4'd0);
        step();
        @(negedge clk); check("full_ignores_issue", 32'(rs_full), 32'd1);
        for (int i = 0; i < 16; i++) begin
            fill_b[i].val1 = 32'h900;
            exp_q.push_back(fill_b[i]);
        end
        drive_alu(4'd9, 32'h900);
        step();
        @(negedge clk);
        check("full_before_dispatch", 32'(rs_full), 32'd1);
        check("burst_not_same_edge", 32'(alu_en), 32'd0);
        for (int j = 0; j < 16; j++) begin
            step();
            @(negedge clk);
            check("burst_en", 32'(alu_en), 32'd1);
            if (j == 0) check("full_drops", 32'(rs_full), 32'd0);
        end
        step();
        @(negedge clk); check("burst_end", 32'(alu_en), 32'd0);

        // Rollback discards waiting entries, a ready entry, and a same-cycle issue.
        drive_issue(mk(7'b0110011, 3'd0, 1'b0, 32'h0, 32'h1, 32'h0, 4'd1, 32'h500), 1'b0, 4'd5,
                    1'b1, 4'd0);
        step();
        drive_issue(mk(7'b0110011, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0, 4'd2, 32'h504), 1'b0, 4'd5,
                    1'b0, 4'd5);
        step();
        drive_issue(mk(7'b0110011, 3'd0, 1'b0, 32'h7, 32'h7, 32'h0, 4'd3, 32'h508), 1'b1, 4'd0,
                    1'b1, 4'd0);
        step();
        drive_issue(mk(7'b0110011, 3'd0, 1'b0, 32'h8, 32'h8, 32'h0, 4'd4, 32'h50C), 1'b1, 4'd0,
                    1'b1, 4'd0);
        drive_alu(4'd5, 32'h55);
        rollback = 1'b1;
        step();
        @(negedge clk);
        check("rollback_alu_en", 32'(alu_en), 32'd0);
        check("rollback_rs_full", 32'(rs_full), 32'd0);
        drive_alu(4'd5, 32'h55);
        step(); step(); step();
        @(negedge clk); check("rollback_no_dispatch", 32'(alu_en), 32'd0);

        // Asynchronous reset while alu_en is high.
        b = mk(7'b0110011, 3'd2, 1'b0, 32'h66, 32'h67, 32'h0, 4'd6, 32'h600);
        drive_issue(b, 1'b1, 4'd0, 1'b1, 4'd0);
        exp_q.push_back(b);
        step();
        drive_issue(mk(7'b0110011, 3'd0, 1'b0, 32'h0, 32'h1, 32'h0, 4'd7, 32'h604), 1'b0, 4'd8,
                    1'b1, 4'd0);
        step();
        @(negedge clk); check("pre_reset_en", 32'(alu_en), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_en", 32'(alu_en), 32'd0);
        check("async_reset_val1", alu_val1, 32'd0);
        check("async_reset_rob", 32'(alu_rob_pos), 32'd0);
        check("async_reset_full", 32'(rs_full), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive_alu(4'd8, 32'h88);
        step(); step(); step();
        @(negedge clk); check("reset_cleared_entries", 32'(alu_en), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
